load_store_unit: RTL and testbench

Executes RV32E LB/LH/LW/LBU/LHU/SB/SH/SW over a byte-serial memory bus, one byte per request/acknowledge handshake, little-endian.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_load_extend.sv | 19 +
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and size helpers for the byte-serial load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Number of bytes moved for a given funct3 (size lives in the low two bits).
    function automatic logic [2:0] byte_count(input logic [2:0] f3);
        logic [2:0] n;
        case (f3[1:0])
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Stores have no unsigned variants, so funct3[2] is only legal on loads.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic store);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign- or zero-extends an assembled little-endian load result to 32 bits.
module lsu_load_extend (
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] value_c
);

    // Pick the extension from the access size and signedness.
    always_comb begin
        value_c = raw;
        case (size)
            2'b00:   value_c = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            2'b01:   value_c = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: value_c = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32E load/store unit driving a byte-serial request/acknowledge memory bus.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       base,
    input  logic [11:0]       offset,
    input  logic [31:0]       store_data,
    input  logic [3:0]        rd,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [3:0]        wb_reg,
    output logic [31:0]       wb_value,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    state_t            state, state_d;
    logic [ADDR_W-1:0] ea_q, ea_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              store_q, store_d;
    logic [3:0]        rd_q, rd_d;
    logic [31:0]       sdata_q, sdata_d;
    logic [31:0]       result_q, result_d;

    logic              busy_d, done_d, error_d;
    logic [3:0]        wb_reg_d;
    logic [31:0]       wb_value_d;
    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_wdata_d;

    logic [ADDR_W-1:0] start_ea_c;
    logic [31:0]       ext_value_c;

    assign start_ea_c = ADDR_W'(base + {{20{offset[11]}}, offset});

    // Extension sees the result including the byte captured this cycle.
    lsu_load_extend u_extend (
        .raw     (result_d),
        .size    (size_q),
        .uns     (uns_q),
        .value_c (ext_value_c)
    );

    // Next-state, latched operands and next registered outputs.
    always_comb begin
        state_d     = state;
        ea_d        = ea_q;
        idx_d       = idx_q;
        last_d      = last_q;
        size_d      = size_q;
        uns_d       = uns_q;
        store_d     = store_q;
        rd_d        = rd_q;
        sdata_d     = sdata_q;
        result_d    = result_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        wb_reg_d    = 4'h0;
        wb_value_d  = 32'h0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = 8'h0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    ea_d     = start_ea_c;
                    idx_d    = 2'd0;
                    last_d   = 2'(byte_count(funct3) - 3'd1);
                    size_d   = funct3[1:0];
                    uns_d    = funct3[2];
                    store_d  = is_store;
                    rd_d     = rd;
                    sdata_d  = store_data;
                    result_d = 32'h0;
                    if (funct3_legal(funct3, is_store)) begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = start_ea_c;
                        mem_we_d    = is_store;
                        mem_wdata_d = store_data[7:0];
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem_req && mem_ack) begin
                    if (!store_q) begin
                        result_d[{idx_q, 3'b000} +: 8] = mem_rdata;
                    end
                    if (idx_q == last_q) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        if (!store_q && (rd_q != 4'h0)) begin
                            wb_reg_d   = rd_q;
                            wb_value_d = ext_value_c;
                        end
                    end else begin
                        state_d = S_GAP;
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = mem_addr;
                    mem_we_d    = mem_we;
                    mem_wdata_d = mem_wdata;
                end
            end
            S_GAP: begin
                state_d     = S_REQ;
                mem_req_d   = 1'b1;
                mem_addr_d  = ea_q + ADDR_W'(idx_q);
                mem_we_d    = store_q;
                mem_wdata_d = sdata_q[{idx_q, 3'b000} +: 8];
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ea_q      <= '0;
            idx_q     <= 2'd0;
            last_q    <= 2'd0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            store_q   <= 1'b0;
            rd_q      <= 4'h0;
            sdata_q   <= 32'h0;
            result_q  <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            wb_reg    <= 4'h0;
            wb_value  <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h0;
        end else begin
            state     <= state_d;
            ea_q      <= ea_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            store_q   <= store_d;
            rd_q      <= rd_d;
            sdata_q   <= sdata_d;
            result_q  <= result_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
            wb_reg    <= wb_reg_d;
            wb_value  <= wb_value_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory responder.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 24;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              is_store;
    logic [2:0]        funct3;
    logic [31:0]       base;
    logic [11:0]       offset;
    logic [31:0]       store_data;
    logic [3:0]        rd;
    logic              busy;
    logic              done;
    logic              error;
    logic [3:0]        wb_reg;
    logic [31:0]       wb_value;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    int total = 0;
    int bad   = 0;
    int ack_delay = 0;
    int wcnt = 0;

    logic [7:0] mem [logic [23:0]];

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .base       (base),
        .offset     (offset),
        .store_data (store_data),
        .rd         (rd),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .wb_reg     (wb_reg),
        .wb_value   (wb_value),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: acknowledges each request after ack_delay wait cycles.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt >= ack_delay) begin
                mem_ack = 1'b1;
                if (mem_we) mem[mem_addr] = mem_wdata;
                else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},   64'(busy),      64'(0));
        chk({tag, "_done"},   64'(done),      64'(0));
        chk({tag, "_error"},  64'(error),     64'(0));
        chk({tag, "_wbreg"},  64'(wb_reg),    64'(0));
        chk({tag, "_wbval"},  64'(wb_value),  64'(0));
        chk({tag, "_req"},    64'(mem_req),   64'(0));
        chk({tag, "_we"},     64'(mem_we),    64'(0));
        chk({tag, "_addr"},   64'(mem_addr),  64'(0));
        chk({tag, "_wdata"},  64'(mem_wdata), 64'(0));
    endtask

    // Issue one operation and check bus traffic, latency and write-back.
    task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] b, input logic [11:0] off,
                          input logic [31:0] sd, input logic [3:0] r, input int dly,
                          input int exp_n, input int exp_cyc, input logic exp_err,
                          input logic [3:0] exp_reg, input logic [31:0] exp_val,
                          input int pulse_at);
        logic [23:0] ea_m;
        int  cyc;
        int  k;
        logic prev_req;
        logic seen;
        ea_m = 24'(b + {{20{off[11]}}, off});
        ack_delay = dly;
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; base = b; offset = off;
        store_data = sd; rd = r;
        cyc = 0; k = 0; prev_req = 1'b0; seen = 1'b0;
        while (cyc < 100 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == pulse_at) begin
                start = 1'b1; is_store = 1'b0; funct3 = 3'b000;
                base = 32'h20; offset = 12'h0; rd = 4'd9;
            end else begin
                start = 1'b0;
            end
            if (cyc == 1) chk({tag, "_busy1"}, 64'(busy), 64'(1));
            if (mem_req) begin
                chk({tag, "_addr"}, 64'(mem_addr), 64'(24'(ea_m + 24'(k))));
                chk({tag, "_we"}, 64'(mem_we), 64'(st));
                if (st) chk({tag, "_wdata"}, 64'(mem_wdata), 64'(8'(sd >> (8 * k))));
            end
            if (prev_req && !mem_req) k++;
            prev_req = mem_req;
            if (done) seen = 1'b1;
        end
        chk({tag, "_seen_done"}, 64'(seen), 64'(1));
        chk({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_bytes"}, 64'(k), 64'(exp_n));
        chk({tag, "_busy_done"}, 64'(busy), 64'(1));
        chk({tag, "_error"}, 64'(error), 64'(exp_err));
        chk({tag, "_wbreg"}, 64'(wb_reg), 64'(exp_reg));
        chk({tag, "_wbval"}, 64'(wb_value), 64'(exp_val));
    endtask

    initial begin
        int  cyc;
        int  k;
        logic prev_req;
        logic seen;

        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        base = 32'h0; offset = 12'h0; store_data = 32'h0; rd = 4'h0;
        mem_rdata = 8'h00; mem_ack = 1'b0;

        mem[24'h000104] = 8'h78; mem[24'h000105] = 8'h56;
        mem[24'h000106] = 8'h34; mem[24'h000107] = 8'h12;
        mem[24'h000020] = 8'h80; mem[24'h000021] = 8'h80;
        mem[24'h000022] = 8'hFF;

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        run_op("lw",  1'b0, 3'b010, 32'h100, 12'd4, 32'h0, 4'd5, 0, 4, 8, 1'b0, 4'd5, 32'h12345678, 0);
        run_op("lb",  1'b0, 3'b000, 32'h20, 12'd0, 32'h0, 4'd3, 0, 1, 2, 1'b0, 4'd3, 32'hFFFFFF80, 0);
        run_op("lbu", 1'b0, 3'b100, 32'h20, 12'd0, 32'h0, 4'd3, 0, 1, 2, 1'b0, 4'd3, 32'h00000080, 0);
        run_op("lh",  1'b0, 3'b001, 32'h20, 12'd1, 32'h0, 4'd3, 0, 2, 4, 1'b0, 4'd3, 32'hFFFFFF80, 0);
        run_op("lhu", 1'b0, 3'b101, 32'h22, 12'hFFF, 32'h0, 4'd4, 0, 2, 4, 1'b0, 4'd4, 32'h0000FF80, 0);
        run_op("lw_r0", 1'b0, 3'b010, 32'h104, 12'd0, 32'h0, 4'd0, 0, 4, 8, 1'b0, 4'd0, 32'h0, 0);

        run_op("sh_wrap", 1'b1, 3'b001, 32'h00FFFFFF, 12'd0, 32'hAABBCCDD, 4'd6, 0, 2, 4, 1'b0, 4'd0, 32'h0, 0);
        chk("sh_mem_ffffff", 64'(mem[24'hFFFFFF]), 64'(8'hDD));
        chk("sh_mem_000000", 64'(mem[24'h000000]), 64'(8'hCC));

        run_op("sw_wait", 1'b1, 3'b010, 32'h200, 12'hFFC, 32'h11223344, 4'd7, 3, 4, 20, 1'b0, 4'd0, 32'h0, 7);
        chk("sw_mem_1fc", 64'(mem[24'h0001FC]), 64'(8'h44));
        chk("sw_mem_1fd", 64'(mem[24'h0001FD]), 64'(8'h33));
        chk("sw_mem_1fe", 64'(mem[24'h0001FE]), 64'(8'h22));
        chk("sw_mem_1ff", 64'(mem[24'h0001FF]), 64'(8'h11));

        run_op("ill_011", 1'b0, 3'b011, 32'h100, 12'd0, 32'h0, 4'd5, 0, 0, 1, 1'b1, 4'd0, 32'h0, 0);
        run_op("ill_sbu", 1'b1, 3'b100, 32'h100, 12'd0, 32'h55, 4'd5, 0, 0, 1, 1'b1, 4'd0, 32'h0, 0);

        // Reset during the third byte request of a word load.
        ack_delay = 0;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h100;
        offset = 12'd4; rd = 4'd7;
        cyc = 0; k = 0; prev_req = 1'b0; seen = 1'b0;
        while (cyc < 50 && !seen) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (prev_req && !mem_req) k++;
            prev_req = mem_req;
            if (k == 2 && mem_req) seen = 1'b1;
        end
        chk("rst_hit_cycle", 64'(cyc), 64'(5));
        chk("rst_hit_addr", 64'(mem_addr), 64'(24'h000106));
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle_outputs("rst_mid");
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || mem_req || wb_reg != 4'h0) seen = 1'b1;
        end
        chk("rst_quiet", 64'(seen), 64'(0));

        run_op("lb_after_rst", 1'b0, 3'b000, 32'h20, 12'd0, 32'h0, 4'd3, 0, 1, 2, 1'b0, 4'd3, 32'hFFFFFF80, 0);

        @(negedge clk);
        chk("final_idle_busy", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
